// File: rtl/colour_arb.sv
// -----------------------------------------------------------------------------
// colour_arb
//   Shares one external combinational colour mapper (phase/log_mag -> RGB)
//   between two sample streams. Arbitration is round-robin and line-atomic:
//   once granted, a source keeps the mapper until it sends a 'last' beat, or
//   until MAX_BURST beats have been accepted, whichever comes first.
//
//   Two-stage pipeline:
//     stage A : registered mapper operands plus {valid, src, last}
//     stage B : captured mapper result, presented as the m_* output stream
//   A beat accepted at edge t is visible on m_* (m_valid=1) after edge t+1.
//
// Parameters
//   MAX_BURST  beats per grant before a forced release (1..65535)
//   RR_INIT    source that wins the first contended arbitration after reset
//
// Ports
//   clk, rst_n                       clock, asynchronous active-low reset
//   s0_valid/ready/phase/log_mag/last  source 0 sample stream
//   s1_valid/ready/phase/log_mag/last  source 1 sample stream
//   map_phase, map_log_mag           operands to the shared mapper (stage A)
//   map_red, map_green, map_blue     mapper result (combinational from map_*)
//   m_valid/ready/rgb/src/last       tagged RGB output stream
//   burst_trunc                      one-cycle pulse on a forced release
// -----------------------------------------------------------------------------
module colour_arb #(
    parameter int unsigned MAX_BURST = 640,
    parameter bit          RR_INIT   = 1'b0
) (
    input  logic        clk,
    input  logic        rst_n,

    input  logic        s0_valid,
    output logic        s0_ready,
    input  logic [7:0]  s0_phase,
    input  logic [7:0]  s0_log_mag,
    input  logic        s0_last,

    input  logic        s1_valid,
    output logic        s1_ready,
    input  logic [7:0]  s1_phase,
    input  logic [7:0]  s1_log_mag,
    input  logic        s1_last,

    output logic [7:0]  map_phase,
    output logic [7:0]  map_log_mag,
    input  logic [7:0]  map_red,
    input  logic [7:0]  map_green,
    input  logic [7:0]  map_blue,

    output logic        m_valid,
    input  logic        m_ready,
    output logic [23:0] m_rgb,
    output logic        m_src,
    output logic        m_last,

    output logic        burst_trunc
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        GNT0 = 2'd1,
        GNT1 = 2'd2
    } state_t;

    // Beat index at which a grant without 'last' is forcibly released.
    localparam logic [15:0] CNT_LAST = 16'(MAX_BURST - 1);

    state_t      state;
    state_t      state_nxt;
    logic        rr_ptr;
    logic        rr_nxt;
    logic [15:0] beat_cnt;
    logic [15:0] cnt_nxt;
    logic        trunc_nxt;

    logic        a_valid;
    logic        a_src;
    logic        a_last;

    logic        adv_a;
    logic        adv_b;
    logic        accept;
    logic        gnt_src;
    logic [7:0]  gnt_phase;
    logic [7:0]  gnt_log_mag;
    logic        gnt_last;

    // Each stage may load when it is empty or when the stage after it drains.
    assign adv_b  = !m_valid || m_ready;
    assign adv_a  = !a_valid || adv_b;
    assign accept = (s0_valid && s0_ready) || (s1_valid && s1_ready);

    // Fields of the granted source; only meaningful while accept is high.
    assign gnt_src     = (state == GNT1);
    assign gnt_phase   = gnt_src ? s1_phase   : s0_phase;
    assign gnt_log_mag = gnt_src ? s1_log_mag : s0_log_mag;
    assign gnt_last    = gnt_src ? s1_last    : s0_last;

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    // NOTE: every flop is written with <= so all registers update together
    // from the values present before the edge, independent of block order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            rr_ptr      <= RR_INIT;
            beat_cnt    <= '0;
            burst_trunc <= 1'b0;
        end else begin
            state       <= state_nxt;
            rr_ptr      <= rr_nxt;
            beat_cnt    <= cnt_nxt;
            burst_trunc <= trunc_nxt;
        end
    end

    // ------------------------------------------------------------------
    // FSM: next-state logic
    // ------------------------------------------------------------------
    // NOTE: every signal gets a default before the case statement so no path
    // leaves it unassigned; an unassigned path would infer a latch.
    always_comb begin
        state_nxt = state;
        rr_nxt    = rr_ptr;
        cnt_nxt   = beat_cnt;
        trunc_nxt = 1'b0;
        unique case (state)
            IDLE: begin
                // The IDLE cycle is the one-bubble cost of a new grant.
                if (s0_valid && s1_valid) begin
                    state_nxt = rr_ptr ? GNT1 : GNT0;
                end else if (s0_valid) begin
                    state_nxt = GNT0;
                end else if (s1_valid) begin
                    state_nxt = GNT1;
                end
            end
            GNT0, GNT1: begin
                if (accept) begin
                    if (gnt_last || beat_cnt == CNT_LAST) begin
                        state_nxt = IDLE;
                        rr_nxt    = ~gnt_src;
                        cnt_nxt   = '0;
                        trunc_nxt = !gnt_last;
                    end else begin
                        cnt_nxt = beat_cnt + 16'd1;
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // FSM: outputs
    // ------------------------------------------------------------------
    always_comb begin
        s0_ready = (state == GNT0) && adv_a;
        s1_ready = (state == GNT1) && adv_a;
    end

    // ------------------------------------------------------------------
    // Pipeline: stage A (mapper operands) and stage B (output register)
    // ------------------------------------------------------------------
    // NOTE: data registers are reset along with the valids so the mapper
    // operands and m_rgb read as zero after reset rather than as X.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_valid     <= 1'b0;
            a_src       <= 1'b0;
            a_last      <= 1'b0;
            map_phase   <= '0;
            map_log_mag <= '0;
            m_valid     <= 1'b0;
            m_rgb       <= '0;
            m_src       <= 1'b0;
            m_last      <= 1'b0;
        end else begin
            if (adv_b) begin
                m_valid <= a_valid;
                if (a_valid) begin
                    m_rgb  <= {map_red, map_green, map_blue};
                    m_src  <= a_src;
                    m_last <= a_last;
                end
            end
            if (adv_a) begin
                a_valid <= accept;
                if (accept) begin
                    map_phase   <= gnt_phase;
                    map_log_mag <= gnt_log_mag;
                    a_src       <= gnt_src;
                    a_last      <= gnt_last;
                end
            end
        end
    end

endmodule

// File: tb/tb_colour_arb.sv
// -----------------------------------------------------------------------------
// tb_colour_arb
//   Directed bench for colour_arb (MAX_BURST=4, RR_INIT=0). A background
//   driver feeds per-source beat queues onto s0/s1 and logs every input and
//   output handshake with its clock edge number; each test task pushes its
//   stimulus, waits (bounded) for the outputs and compares against values
//   it computes itself. The shared mapper is modelled in the bench.
// -----------------------------------------------------------------------------
module tb_colour_arb;

    typedef struct packed {
        logic [7:0] phase;
        logic [7:0] mag;
        logic       last;
    } beat_t;

    typedef struct {
        logic [23:0] rgb;
        logic        src;
        logic        last;
        int          edge_no;
    } out_t;

    typedef struct {
        logic src;
        int   edge_no;
    } acc_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        s0_valid = 1'b0, s0_ready, s0_last = 1'b0;
    logic [7:0]  s0_phase = '0, s0_log_mag = '0;
    logic        s1_valid = 1'b0, s1_ready, s1_last = 1'b0;
    logic [7:0]  s1_phase = '0, s1_log_mag = '0;
    logic [7:0]  map_phase, map_log_mag, map_red, map_green, map_blue;
    logic        m_valid, m_ready = 1'b1, m_src, m_last, burst_trunc;
    logic [23:0] m_rgb;

    int     n_checks = 0;
    int     n_pass = 0;
    int     cyc = 0;
    logic   m_rdy = 1'b1;
    logic   fire0 = 1'b0, fire1 = 1'b0;
    int     trunc_cnt = 0;
    int     trunc_edge = -1;
    beat_t  q0[$];
    beat_t  q1[$];
    out_t   out_log[$];
    acc_t   acc_log[$];

    colour_arb #(.MAX_BURST(4), .RR_INIT(1'b0)) dut (
        .clk(clk), .rst_n(rst_n),
        .s0_valid(s0_valid), .s0_ready(s0_ready), .s0_phase(s0_phase),
        .s0_log_mag(s0_log_mag), .s0_last(s0_last),
        .s1_valid(s1_valid), .s1_ready(s1_ready), .s1_phase(s1_phase),
        .s1_log_mag(s1_log_mag), .s1_last(s1_last),
        .map_phase(map_phase), .map_log_mag(map_log_mag),
        .map_red(map_red), .map_green(map_green), .map_blue(map_blue),
        .m_valid(m_valid), .m_ready(m_ready), .m_rgb(m_rgb),
        .m_src(m_src), .m_last(m_last), .burst_trunc(burst_trunc)
    );

    // Mapper model: a small base palette scaled by log magnitude (c*mag>>8).
    function automatic logic [7:0] scale(input logic [7:0] c, input logic [7:0] m);
        logic [15:0] p;
        p = 16'(c) * 16'(m);
        return p[15:8];
    endfunction

    function automatic logic [23:0] model_rgb(input logic [7:0] ph, input logic [7:0] mg);
        logic [7:0] r, g, b;
        if (ph == 8'h00) begin
            r = 8'd0;   g = 8'd255; b = 8'd252;
        end else if (ph == 8'h80) begin
            r = 8'd255; g = 8'd0;   b = 8'd0;
        end else begin
            r = ph;     g = ~ph;    b = ph ^ 8'h5A;
        end
        return {scale(r, mg), scale(g, mg), scale(b, mg)};
    endfunction

    assign {map_red, map_green, map_blue} = model_rgb(map_phase, map_log_mag);

    always #5 clk = ~clk;

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    // Source/sink driver and handshake monitor. Inputs change on the falling
    // edge; handshakes for the coming rising edge are logged 1 ns later.
    initial forever begin
        @(negedge clk);
        if (fire0 && q0.size() > 0) void'(q0.pop_front());
        if (fire1 && q1.size() > 0) void'(q1.pop_front());
        if (q0.size() > 0) begin
            s0_valid = 1'b1;
            {s0_phase, s0_log_mag, s0_last} = q0[0];
        end else begin
            s0_valid = 1'b0;
            {s0_phase, s0_log_mag, s0_last} = '0;
        end
        if (q1.size() > 0) begin
            s1_valid = 1'b1;
            {s1_phase, s1_log_mag, s1_last} = q1[0];
        end else begin
            s1_valid = 1'b0;
            {s1_phase, s1_log_mag, s1_last} = '0;
        end
        m_ready = m_rdy;
        #1;
        fire0 = s0_valid && s0_ready;
        fire1 = s1_valid && s1_ready;
        if (fire0) acc_log.push_back('{1'b0, cyc + 1});
        if (fire1) acc_log.push_back('{1'b1, cyc + 1});
        if (m_valid && m_ready) out_log.push_back('{m_rgb, m_src, m_last, cyc + 1});
        if (burst_trunc) begin
            trunc_cnt++;
            trunc_edge = cyc;
        end
    end

    task automatic clear_logs();
        out_log.delete();
        acc_log.delete();
        trunc_cnt  = 0;
        trunc_edge = -1;
    endtask

    task automatic apply_reset();
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        q0.delete();
        q1.delete();
        fire0 = 1'b0;
        fire1 = 1'b0;
        m_rdy = 1'b1;
        clear_logs();
        @(negedge clk);
        #2;
        rst_n = 1'b1;
    endtask

    task automatic wait_outs(input int n, input int budget, input string name, output bit ok);
        int k = 0;
        while (out_log.size() < n && k < budget) begin
            @(negedge clk);
            #2;
            k++;
        end
        n_checks++;
        ok = (out_log.size() >= n);
        if (!ok) $display("FAIL %s: timeout with %0d output beats, required %0d", name, out_log.size(), n);
        else n_pass++;
    endtask

    task automatic test_reset();
        @(negedge clk);
        #2;
        n_checks++; if (m_valid !== 1'b0) $display("FAIL reset_m_valid: got %b want 0", m_valid); else n_pass++;
        n_checks++; if (s0_ready !== 1'b0) $display("FAIL reset_s0_ready: got %b want 0", s0_ready); else n_pass++;
        n_checks++; if (s1_ready !== 1'b0) $display("FAIL reset_s1_ready: got %b want 0", s1_ready); else n_pass++;
        n_checks++; if (m_rgb !== 24'h0) $display("FAIL reset_m_rgb: got %h want 000000", m_rgb); else n_pass++;
        n_checks++; if ({map_phase, map_log_mag} !== 16'h0) $display("FAIL reset_map: got %h want 0000", {map_phase, map_log_mag}); else n_pass++;
        n_checks++; if ({m_src, m_last, burst_trunc} !== 3'b000) $display("FAIL reset_flags: got %b want 000", {m_src, m_last, burst_trunc}); else n_pass++;
        rst_n = 1'b1;
    endtask

    task automatic test_single_line();
        bit ok;
        clear_logs();
        for (int i = 0; i < 4; i++) q0.push_back('{8'h80, 8'hFF, (i == 3)});
        wait_outs(4, 50, "single_line_done", ok);
        if (ok) begin
            for (int i = 0; i < 4; i++) begin
                n_checks++; if (out_log[i].rgb !== 24'hFE0000) $display("FAIL single_rgb[%0d]: got %h want fe0000", i, out_log[i].rgb); else n_pass++;
                n_checks++; if (out_log[i].src !== 1'b0) $display("FAIL single_src[%0d]: got %b want 0", i, out_log[i].src); else n_pass++;
                n_checks++; if (out_log[i].last !== (i == 3)) $display("FAIL single_last[%0d]: got %b want %b", i, out_log[i].last, (i == 3)); else n_pass++;
                n_checks++;
                if (acc_log.size() <= i || out_log[i].edge_no - acc_log[i].edge_no != 2)
                    $display("FAIL single_latency[%0d]: got out edge %0d, acceptance log size %0d, want 2 edges after acceptance", i, out_log[i].edge_no, acc_log.size());
                else n_pass++;
            end
        end
    endtask

    task automatic test_colour();
        bit ok;
        clear_logs();
        q0.push_back('{8'h00, 8'h80, 1'b1});
        wait_outs(1, 30, "colour_done", ok);
        if (ok) begin
            n_checks++; if (out_log[0].rgb !== 24'h007F7E) $display("FAIL colour_rgb: got %h want 007f7e", out_log[0].rgb); else n_pass++;
            n_checks++; if (out_log[0].last !== 1'b1) $display("FAIL colour_last: got %b want 1", out_log[0].last); else n_pass++;
        end
    endtask

    task automatic test_round_robin();
        bit    ok;
        out_t  exp_q[$];
        beat_t b;
        apply_reset();
        // Two 3-beat lines per source; both sources valid throughout.
        for (int l = 0; l < 2; l++) begin
            for (int i = 0; i < 3; i++) begin
                q0.push_back('{8'(8'h11 + 3 * l + i), 8'(8'h90 + i), (i == 2)});
                q1.push_back('{8'(8'h41 + 3 * l + i), 8'(8'hA0 + i), (i == 2)});
            end
        end
        for (int l = 0; l < 4; l++) begin
            for (int i = 0; i < 3; i++) begin
                if (l[0] == 1'b0) b = '{8'(8'h11 + 3 * (l / 2) + i), 8'(8'h90 + i), (i == 2)};
                else              b = '{8'(8'h41 + 3 * (l / 2) + i), 8'(8'hA0 + i), (i == 2)};
                exp_q.push_back('{model_rgb(b.phase, b.mag), l[0], b.last, 0});
            end
        end
        wait_outs(12, 100, "rr_done", ok);
        if (ok) begin
            for (int i = 0; i < 12; i++) begin
                n_checks++; if (out_log[i].src !== exp_q[i].src) $display("FAIL rr_src[%0d]: got %b want %b", i, out_log[i].src, exp_q[i].src); else n_pass++;
                n_checks++; if (out_log[i].rgb !== exp_q[i].rgb) $display("FAIL rr_rgb[%0d]: got %h want %h", i, out_log[i].rgb, exp_q[i].rgb); else n_pass++;
                n_checks++; if (out_log[i].last !== exp_q[i].last) $display("FAIL rr_last[%0d]: got %b want %b", i, out_log[i].last, exp_q[i].last); else n_pass++;
            end
            // Back-to-back within a line, exactly one bubble between lines.
            for (int i = 1; i < 12; i++) begin
                n_checks++;
                if (acc_log[i].edge_no - acc_log[i - 1].edge_no != ((i % 3 == 0) ? 2 : 1))
                    $display("FAIL rr_gap[%0d]: got %0d edges want %0d", i, acc_log[i].edge_no - acc_log[i - 1].edge_no, (i % 3 == 0) ? 2 : 1);
                else n_pass++;
            end
        end
    endtask

    task automatic test_stall();
        bit         ok;
        beat_t      line[8];
        int         k_hold;
        logic [23:0] held;
        apply_reset();
        for (int i = 0; i < 8; i++) begin
            line[i] = '{8'(8'h30 + 8'h07 * i), 8'(8'hC0 - 8'h05 * i), (i == 7)};
            q0.push_back(line[i]);
        end
        wait_outs(2, 40, "stall_start", ok);
        if (ok) begin
            m_rdy  = 1'b0;
            k_hold = out_log.size();
            held   = model_rgb(line[k_hold].phase, line[k_hold].mag);
            for (int c = 0; c < 5; c++) begin
                @(negedge clk);
                #2;
                n_checks++; if (m_valid !== 1'b1) $display("FAIL stall_valid[%0d]: got %b want 1", c, m_valid); else n_pass++;
                n_checks++; if (m_rgb !== held) $display("FAIL stall_rgb[%0d]: got %h want %h", c, m_rgb, held); else n_pass++;
                n_checks++; if (s0_ready !== 1'b0) $display("FAIL stall_ready[%0d]: got %b want 0", c, s0_ready); else n_pass++;
            end
            m_rdy = 1'b1;
        end
        wait_outs(8, 60, "stall_done", ok);
        if (ok) begin
            for (int i = 0; i < 8; i++) begin
                n_checks++;
                if (out_log[i].rgb !== model_rgb(line[i].phase, line[i].mag) || out_log[i].last !== line[i].last)
                    $display("FAIL stall_seq[%0d]: got %h/%b want %h/%b", i, out_log[i].rgb, out_log[i].last, model_rgb(line[i].phase, line[i].mag), line[i].last);
                else n_pass++;
            end
        end
        repeat (5) @(negedge clk);
        #2;
        n_checks++; if (out_log.size() != 8) $display("FAIL stall_count: got %0d beats want 8", out_log.size()); else n_pass++;
    endtask

    task automatic test_burst_trunc();
        bit    ok;
        int    k = 0;
        beat_t b1[6];
        beat_t b0[2];
        out_t  exp_q[$];
        apply_reset();
        for (int i = 0; i < 6; i++) begin
            b1[i] = '{8'(8'h61 + i), 8'(8'hE0 + i), 1'b0};
            q1.push_back(b1[i]);
        end
        while (acc_log.size() < 1 && k < 20) begin
            @(negedge clk);
            #2;
            k++;
        end
        for (int i = 0; i < 2; i++) begin
            b0[i] = '{8'(8'hB1 + i), 8'(8'h70 + i), (i == 1)};
            q0.push_back(b0[i]);
        end
        for (int i = 0; i < 4; i++) exp_q.push_back('{model_rgb(b1[i].phase, b1[i].mag), 1'b1, 1'b0, 0});
        for (int i = 0; i < 2; i++) exp_q.push_back('{model_rgb(b0[i].phase, b0[i].mag), 1'b0, b0[i].last, 0});
        for (int i = 4; i < 6; i++) exp_q.push_back('{model_rgb(b1[i].phase, b1[i].mag), 1'b1, 1'b0, 0});
        wait_outs(8, 80, "trunc_done", ok);
        if (ok) begin
            for (int i = 0; i < 8; i++) begin
                n_checks++;
                if (out_log[i].src !== exp_q[i].src || out_log[i].rgb !== exp_q[i].rgb || out_log[i].last !== exp_q[i].last)
                    $display("FAIL trunc_seq[%0d]: got %b/%h/%b want %b/%h/%b", i, out_log[i].src, out_log[i].rgb, out_log[i].last, exp_q[i].src, exp_q[i].rgb, exp_q[i].last);
                else n_pass++;
            end
            n_checks++; if (trunc_cnt != 1) $display("FAIL trunc_pulses: got %0d want 1", trunc_cnt); else n_pass++;
            n_checks++;
            if (trunc_edge != acc_log[3].edge_no)
                $display("FAIL trunc_timing: pulse after edge %0d want after edge %0d", trunc_edge, acc_log[3].edge_no);
            else n_pass++;
        end
    endtask

    task automatic test_reset_mid_line();
        bit ok;
        int k = 0;
        // Source 1 still holds the grant from the previous test (rr_ptr=1).
        clear_logs();
        for (int i = 0; i < 6; i++) q1.push_back('{8'(8'h21 + i), 8'hD0, (i == 5)});
        while (acc_log.size() < 2 && k < 20) begin
            @(negedge clk);
            #2;
            k++;
        end
        rst_n = 1'b0;
        #1;
        n_checks++; if (m_valid !== 1'b0) $display("FAIL midrst_m_valid: got %b want 0", m_valid); else n_pass++;
        n_checks++; if ({s0_ready, s1_ready} !== 2'b00) $display("FAIL midrst_ready: got %b want 00", {s0_ready, s1_ready}); else n_pass++;
        q0.delete();
        q1.delete();
        fire0 = 1'b0;
        fire1 = 1'b0;
        clear_logs();
        @(negedge clk);
        #2;
        rst_n = 1'b1;
        q0.push_back('{8'h55, 8'hF0, 1'b1});
        q1.push_back('{8'h66, 8'hF0, 1'b1});
        wait_outs(2, 30, "midrst_done", ok);
        if (ok) begin
            n_checks++; if (out_log[0].src !== 1'b0) $display("FAIL midrst_first_src: got %b want 0", out_log[0].src); else n_pass++;
            n_checks++; if (out_log[0].rgb !== model_rgb(8'h55, 8'hF0)) $display("FAIL midrst_rgb0: got %h want %h", out_log[0].rgb, model_rgb(8'h55, 8'hF0)); else n_pass++;
            n_checks++; if (out_log[1].src !== 1'b1) $display("FAIL midrst_second_src: got %b want 1", out_log[1].src); else n_pass++;
            n_checks++; if (out_log[1].rgb !== model_rgb(8'h66, 8'hF0)) $display("FAIL midrst_rgb1: got %h want %h", out_log[1].rgb, model_rgb(8'h66, 8'hF0)); else n_pass++;
        end
    endtask

    initial begin
        test_reset();
        test_single_line();
        test_colour();
        test_round_robin();
        test_stall();
        test_burst_trunc();
        test_reset_mid_line();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
